// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one-outstanding-request fetch FSM with redirect and stale-response discard.
// Optional HALT state on opcode 4'hF is enabled by defining IFU_HALT_EN.
module ifu_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [7:0]  imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_jump,
    input  logic        redirect_branch,
    input  logic [7:0]  redirect_target,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
`ifdef IFU_HALT_EN
        , HALT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  instr_pc_q, instr_pc_d;

    logic redirect;
    logic req_fire;

    assign redirect = redirect_jump | redirect_branch;
    // A request is held back while a stale response is still in flight.
    assign imem_req_valid = (state_q == REQ) && !discard_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        if (redirect) begin
            pc_d    = redirect_target;
            state_d = REQ;
            // Something is still owed by memory unless it is arriving right now.
            discard_d = ((state_q == WAIT) || req_fire || discard_q) && !imem_rsp_valid;
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (discard_q) begin
                        if (imem_rsp_valid) begin
                            discard_d = 1'b0;
                        end
                    end else if (imem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 8'd1;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
`ifdef IFU_HALT_EN
                        state_d = (instr_q[15:12] == 4'hF) ? HALT : REQ;
`else
                        state_d = REQ;
`endif
                    end
                end
`ifdef IFU_HALT_EN
                HALT: state_d = HALT;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            instr_q    <= 16'h0000;
            instr_pc_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[15:12];
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == HOLD);

`ifdef IFU_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 8'h00, the PC loaded at reset.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  input  1  sole clock; all state updates on its rising edge
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- imem_req_valid  output  1  instruction-memory read request valid
- imem_req_ready  input  1  memory accepts the request this cycle
- imem_addr  output  8  word address of the request (current PC)
- imem_rsp_valid  input  1  read data valid this cycle; always accepted
- imem_rdata  input  16  instruction word
- instr  output  16  held instruction
- opcode  output  4  instr[15:12], fed to the decoder
- instr_pc  output  8  address of the held instruction
- instr_valid  output  1  instr/opcode valid
- instr_ready  input  1  downstream consumes the instruction this cycle
- redirect_jump  input  1  jump to redirect_target
- redirect_branch  input  1  taken branch to redirect_target
- redirect_target  input  8  new PC
- halted  output  1  fetch stopped (see Configuration)

Function
REQ-003 The block SHALL use the FSM states IDLE, REQ, WAIT and HOLD; state HALT is present only under REQ-016.
REQ-004 IDLE SHALL move to REQ unconditionally on the next cycle. IDLE is entered only from reset.
REQ-005 In REQ the block SHALL assert imem_req_valid with imem_addr=PC, and SHALL hold both stable until imem_req_ready=1, then move to WAIT.
REQ-006 At most one request SHALL be outstanding. imem_req_valid SHALL be 0 outside REQ.
REQ-007 In WAIT, on imem_rsp_valid=1 the block SHALL:
- capture instr=imem_rdata and instr_pc=PC;
- set PC=PC+1, 8-bit, wrapping 8'hFF to 8'h00;
- move to HOLD.
REQ-008 In HOLD, instr_valid SHALL be 1. instr and instr_pc SHALL stay stable until instr_ready=1, then the FSM SHALL move to REQ. Minimum instruction-to-instruction period is 3 cycles with zero-wait memory.
REQ-009 opcode SHALL equal instr[15:12] combinationally at all times.
REQ-010 A redirect (redirect_jump or redirect_branch =1) SHALL take effect in any state:
- PC is set to redirect_target;
- instr_valid drops the next cycle;
- the FSM moves to REQ;
- the first request to the target issues on the cycle after the redirect.
REQ-011 If a redirect occurs in WAIT, or in REQ with imem_req_ready=1, the block SHALL set a discard flag. The next imem_rsp_valid SHALL then be dropped: no capture and no PC increment. The flag clears on that response.
REQ-012 If a response arrives in the same cycle as a redirect, it SHALL be dropped, and no discard flag is set.
REQ-013 If a redirect and instr_ready=1 coincide in HOLD, the held instruction SHALL count as consumed and the redirect SHALL be applied.
REQ-014 While the discard flag is set, the block SHALL be in REQ or WAIT, and the new request SHALL NOT issue until the stale response is dropped.

Reset
REQ-015 With reset_n=0 at a rising edge, the block SHALL set:
- state=IDLE, PC=RESET_PC, discard flag=0;
- instr=16'h0000, instr_pc=8'h00;
- instr_valid=0, imem_req_valid=0, halted=0.
Reset applied mid-request SHALL abandon that request, with no discard tracking.

Configuration
REQ-016 With IFU_HALT_EN defined:
- an instruction with opcode 4'b1111 SHALL, when consumed, move the FSM to HALT;
- HALT asserts halted=1 and issues no requests;
- only reset or a redirect leaves HALT; a redirect goes to REQ and clears halted.
Without IFU_HALT_EN, opcode 4'b1111 SHALL be fetched and delivered like any other opcode, and halted SHALL be tied to 0.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset release, zero-wait memory, instr_ready=1, RESET_PC=8'h00 -> requests at addr 00,01,02; instr_valid every 3rd cycle; instr_pc 00,01,02.
- imem_req_ready held 0 for 4 cycles at PC=8'h05 -> imem_addr stays 8'h05 and imem_req_valid stays 1; one accepted request only.
- Redirect to 8'h40 in WAIT at PC=8'h10, response 2 cycles later -> that response dropped; next request addr 8'h40; first delivered instr_pc=8'h40.
- PC=8'hFF fetched and consumed -> next imem_addr=8'h00.
- HOLD with instr_ready=0 for 5 cycles, then redirect_jump and instr_ready both 1 -> instr stable for all 5 cycles; next request at redirect_target.
- IFU_HALT_EN defined, rdata=16'hF000 consumed -> halted=1 and no imem_req_valid; redirect to 8'h20 -> halted=0 and a request at 8'h20.
